// File: rtl/filter_fetch_pkg.sv
// Shared types and constants for the filter weight fetcher.
package filter_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

    // Accept-to-FIFO latency: stage A, stage B, memory return.
    localparam int PIPE_LAT = 3;

endpackage

// File: rtl/weight_fifo.sv
// Synchronous FIFO holding returned weights (plus last flag) for the PE array.
module weight_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags and head word; head reads as zero while empty.
    always_comb begin
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        count     = wr_ptr_r - rd_ptr_r;
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        if (empty) begin
            rdata = {WIDTH{1'b0}};
        end else begin
            rdata = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

    // Pointer update; a push into a full FIFO is taken only alongside a pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // Storage array, no reset needed since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/filter_weight_fetcher.sv
// Converts (filter, channel, row, col) tuples to weight-memory reads and
// streams the returned weights to the PE array under credit-based flow control.
module filter_weight_fetcher
    import filter_fetch_pkg::*;
#(
    parameter int F_WIDTH    = 8,
    parameter int CH_WIDTH   = 5,
    parameter int R_WIDTH    = 4,
    parameter int S_WIDTH    = 6,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CH_WIDTH-1:0]   num_ch,
    input  logic [R_WIDTH-1:0]    num_rows,
    input  logic [S_WIDTH-1:0]    num_cols,
    input  logic                  idx_valid,
    input  logic                  idx_last,
    input  logic [F_WIDTH-1:0]    filter_index,
    input  logic [CH_WIDTH-1:0]   channel_index,
    input  logic [R_WIDTH-1:0]    row_index,
    input  logic [S_WIDTH-1:0]    col_index,
    output logic                  await,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  w_valid,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_last,
    input  logic                  w_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int FC_W   = F_WIDTH + CH_WIDTH;
    localparam int FULL_W = FC_W + R_WIDTH + S_WIDTH;
    localparam int OUT_W  = $clog2(FIFO_DEPTH + PIPE_LAT) + 1;
    localparam int FW     = DATA_WIDTH + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OUT_W-1:0] CREDIT_MAX = OUT_W'(FIFO_DEPTH);

    fetch_state_t          state_r;
    fetch_state_t          state_nxt_s;
    logic [CH_WIDTH-1:0]   num_ch_r;
    logic [R_WIDTH-1:0]    num_rows_r;
    logic [S_WIDTH-1:0]    num_cols_r;
    logic [OUT_W-1:0]      outstanding_r;
    logic [OUT_W-1:0]      outstanding_nxt_s;
    logic                  accept_s;
    logic                  pop_s;
    logic                  drained_s;
    logic                  await_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  a_valid_r;
    logic                  a_last_r;
    logic [FC_W-1:0]       a_fc_r;
    logic [R_WIDTH-1:0]    a_row_r;
    logic [S_WIDTH-1:0]    a_col_r;
    logic [FC_W-1:0]       fc_s;
    logic [FULL_W-1:0]     addr_full_s;
    logic                  b_valid_r;
    logic                  b_last_r;
    logic [ADDR_WIDTH-1:0] b_addr_r;
    logic                  ret_valid_r;
    logic                  ret_last_r;

    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic [FW-1:0]         fifo_rdata_s;

    // Handshakes, credit bookkeeping and next-state selection.
    always_comb begin
        accept_s          = (state_r == ST_RUN) && idx_valid && !await_r;
        pop_s             = !fifo_empty_s && w_ready;
        drained_s         = !a_valid_r && !b_valid_r && !ret_valid_r &&
                            (fifo_count_s == {CNT_W{1'b0}});
        outstanding_nxt_s = outstanding_r + OUT_W'(accept_s) - OUT_W'(pop_s);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && idx_last) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drained_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Stage A product and stage B address at full width before truncation.
    always_comb begin
        fc_s        = FC_W'(filter_index) * FC_W'(num_ch_r) + FC_W'(channel_index);
        addr_full_s = (FULL_W'(a_fc_r) * FULL_W'(num_rows_r) + FULL_W'(a_row_r)) *
                      FULL_W'(num_cols_r) + FULL_W'(a_col_r);
    end

    // FSM with registered status outputs and credit-derived await.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            outstanding_r <= {OUT_W{1'b0}};
            await_r       <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            num_ch_r      <= {CH_WIDTH{1'b0}};
            num_rows_r    <= {R_WIDTH{1'b0}};
            num_cols_r    <= {S_WIDTH{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            // The full-FIFO term is a redundant guard behind the credit count.
            await_r       <= (state_nxt_s != ST_RUN) || (outstanding_nxt_s >= CREDIT_MAX) ||
                             (fifo_full_s && !pop_s);
            busy_r        <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
            done_r        <= (state_nxt_s == ST_DONE);
            if ((state_r == ST_IDLE) && start) begin
                num_ch_r   <= num_ch;
                num_rows_r <= num_rows;
                num_cols_r <= num_cols;
            end
        end
    end

    // Address pipe and memory-return tracking; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_valid_r   <= 1'b0;
            a_last_r    <= 1'b0;
            a_fc_r      <= {FC_W{1'b0}};
            a_row_r     <= {R_WIDTH{1'b0}};
            a_col_r     <= {S_WIDTH{1'b0}};
            b_valid_r   <= 1'b0;
            b_last_r    <= 1'b0;
            b_addr_r    <= {ADDR_WIDTH{1'b0}};
            ret_valid_r <= 1'b0;
            ret_last_r  <= 1'b0;
        end else begin
            a_valid_r <= accept_s;
            if (accept_s) begin
                a_fc_r   <= fc_s;
                a_row_r  <= row_index;
                a_col_r  <= col_index;
                a_last_r <= idx_last;
            end
            b_valid_r <= a_valid_r;
            if (a_valid_r) begin
                b_addr_r <= ADDR_WIDTH'(addr_full_s);
                b_last_r <= a_last_r;
            end
            ret_valid_r <= b_valid_r;
            ret_last_r  <= b_last_r;
        end
    end

    weight_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ret_valid_r),
        .pop   (pop_s),
        .wdata ({ret_last_r, mem_rdata}),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign await    = await_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign mem_ren  = b_valid_r;
    assign mem_addr = b_addr_r;
    assign w_valid  = !fifo_empty_s;
    assign w_data   = fifo_rdata_s[DATA_WIDTH-1:0];
    assign w_last   = fifo_rdata_s[DATA_WIDTH];

endmodule

// File: tb/tb_filter_weight_fetcher.sv
// Randomized bench for filter_weight_fetcher with an SRAM model and a
// queue-based reference of the expected weight stream.
module tb_filter_weight_fetcher;

    localparam int F_W   = 8;
    localparam int C_W   = 5;
    localparam int R_W   = 4;
    localparam int S_W   = 6;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [C_W-1:0] num_ch;
    logic [R_W-1:0] num_rows;
    logic [S_W-1:0] num_cols;
    logic           idx_valid;
    logic           idx_last;
    logic [F_W-1:0] filter_index;
    logic [C_W-1:0] channel_index;
    logic [R_W-1:0] row_index;
    logic [S_W-1:0] col_index;
    logic           await;
    logic           mem_ren;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_rdata;
    logic           w_valid;
    logic [DW-1:0]  w_data;
    logic           w_last;
    logic           w_ready;
    logic           busy;
    logic           done;

    int checks   = 0;
    int failures = 0;

    typedef struct {int f; int c; int r; int s; bit last;} tup_t;
    typedef struct {logic [DW-1:0] data; logic last;} exp_t;

    tup_t tup_q[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    filter_weight_fetcher dut (
        .clk(clk), .reset(reset), .start(start),
        .num_ch(num_ch), .num_rows(num_rows), .num_cols(num_cols),
        .idx_valid(idx_valid), .idx_last(idx_last),
        .filter_index(filter_index), .channel_index(channel_index),
        .row_index(row_index), .col_index(col_index),
        .await(await), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .w_valid(w_valid), .w_data(w_data), .w_last(w_last), .w_ready(w_ready),
        .busy(busy), .done(done)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] p;
        p = a * 16'h9e37;
        return p ^ 16'h5a5a;
    endfunction

    function automatic logic [AW-1:0] ref_addr(input tup_t t);
        longint full;
        full = ((longint'(t.f) * longint'(num_ch) + t.c) * longint'(num_rows) + t.r)
               * longint'(num_cols) + t.s;
        return AW'(full % (longint'(1) << AW));
    endfunction

    // Synchronous SRAM: data one cycle after a read, garbage otherwise.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem_word(mem_addr);
        else         mem_rdata <= DW'($urandom);
    end

    task automatic run_job(input int ready_mode, input int hold_cycles, input int max_cycles,
                           input bit gaps, output int acc_at_hold, output int stalls);
        int outst = 0;
        int cyc = 0;
        int done_cnt = 0;
        int accepted = 0;
        bit in_run;
        bit acc;
        bit pop;
        bit held_v = 0;
        logic [DW-1:0] held = '0;
        exp_t e;
        stalls = 0;
        acc_at_hold = 0;
        @(negedge clk); start = 1'b1; w_ready = 1'b0;
        in_run = 1'b1;
        while ((tup_q.size() > 0 || exp_q.size() > 0 || done_cnt == 0) && cyc < max_cycles) begin
            @(negedge clk);
            start = 1'b0;
            if (tup_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
                idx_valid = 1'b1;
                filter_index = F_W'(tup_q[0].f); channel_index = C_W'(tup_q[0].c);
                row_index = R_W'(tup_q[0].r); col_index = S_W'(tup_q[0].s);
                idx_last = tup_q[0].last;
            end else begin
                idx_valid = 1'b0; idx_last = 1'b0;
                filter_index = F_W'($urandom); channel_index = C_W'($urandom);
                row_index = R_W'($urandom); col_index = S_W'($urandom);
            end
            if (cyc < hold_cycles) w_ready = 1'b0;
            else if (ready_mode == 1) w_ready = 1'($urandom_range(1));
            else if (ready_mode == 2) w_ready = (cyc % 2 == 0);
            else w_ready = 1'b1;
            checks++;
            if (await !== (!in_run || outst >= DEPTH)) begin
                failures++;
                $display("FAIL credit_await cyc=%0d got=%b expected=%b outstanding=%0d",
                         cyc, await, (!in_run || outst >= DEPTH), outst);
            end
            if (held_v && w_valid) begin
                checks++;
                if (w_data !== held) begin
                    failures++;
                    $display("FAIL hold_stable got=%h expected=%h", w_data, held);
                end
            end
            held_v = w_valid && !w_ready;
            held = w_data;
            pop = w_valid && w_ready;
            if (pop) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_word got=%h expected=none", w_data);
                end else begin
                    e = exp_q.pop_front();
                    if (w_data !== e.data || w_last !== e.last) begin
                        failures++;
                        $display("FAIL word got=%h/%b expected=%h/%b", w_data, w_last, e.data, e.last);
                    end
                end
            end
            acc = idx_valid && !await && in_run;
            if (idx_valid && await && in_run) stalls++;
            if (acc) begin
                exp_q.push_back('{mem_word(ref_addr(tup_q[0])), tup_q[0].last});
                if (tup_q[0].last) in_run = 1'b0;
                void'(tup_q.pop_front());
                accepted++;
            end
            outst = outst + int'(acc) - int'(pop);
            if (done) begin
                done_cnt++;
                checks++;
                if (tup_q.size() != 0 || exp_q.size() != 0 || w_valid) begin
                    failures++;
                    $display("FAIL early_done got=pending expected=drained q=%0d", exp_q.size());
                end
            end
            if (cyc == hold_cycles - 1) acc_at_hold = accepted;
            cyc++;
        end
        idx_valid = 1'b0; idx_last = 1'b0;
        checks++;
        if (cyc >= max_cycles) begin
            failures++;
            $display("FAIL job_timeout got=%0d cycles expected<%0d", cyc, max_cycles);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || await !== 1'b1 || done_cnt != 1) begin
            failures++;
            $display("FAIL job_end got done=%b busy=%b await=%b pulses=%0d expected 0/0/1/1",
                     done, busy, await, done_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (await !== 1'b1 || mem_ren !== 1'b0 || mem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mem got await=%b ren=%b addr=%h expected 1/0/0000", await, mem_ren, mem_addr);
        end
        checks++;
        if (w_valid !== 1'b0 || w_data !== 16'h0000 || w_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got v=%b d=%h l=%b expected 0/0000/0", w_valid, w_data, w_last);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_status got busy=%b done=%b expected 0/0", busy, done);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_tuple();
        tup_t t;
        int waited = 0;
        num_ch = 5'd2; num_rows = 4'd3; num_cols = 6'd3; w_ready = 1'b1;
        t = '{1, 1, 2, 0, 1'b1};
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (busy !== 1'b1 || await !== 1'b0) begin
            failures++;
            $display("FAIL single_run got busy=%b await=%b expected 1/0", busy, await);
        end
        idx_valid = 1'b1; idx_last = 1'b1;
        filter_index = 8'd1; channel_index = 5'd1; row_index = 4'd2; col_index = 6'd0;
        @(negedge clk); idx_valid = 1'b0; idx_last = 1'b0;
        checks++;
        if (mem_ren !== 1'b0 || await !== 1'b1) begin
            failures++;
            $display("FAIL single_stageA got ren=%b await=%b expected 0/1", mem_ren, await);
        end
        @(negedge clk);
        checks++;
        if (mem_ren !== 1'b1 || mem_addr !== ref_addr(t)) begin
            failures++;
            $display("FAIL single_addr got ren=%b addr=%0d expected 1/%0d", mem_ren, mem_addr, ref_addr(t));
        end
        @(negedge clk);
        checks++;
        if (mem_ren !== 1'b0 || w_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_gap got ren=%b w_valid=%b expected 0/0", mem_ren, w_valid);
        end
        @(negedge clk);
        checks++;
        if (w_valid !== 1'b1 || w_data !== mem_word(ref_addr(t)) || w_last !== 1'b1) begin
            failures++;
            $display("FAIL single_word got v=%b d=%h l=%b expected 1/%h/1", w_valid, w_data, w_last,
                     mem_word(ref_addr(t)));
        end
        while (done !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL single_done got=%b expected=1 within 10 cycles", done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_sweep();
        int acc_h;
        int stalls;
        num_ch = 5'd2; num_rows = 4'd3; num_cols = 6'd3;
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 2; c++)
                for (int r = 0; r < 3; r++)
                    for (int s = 0; s < 3; s++)
                        tup_q.push_back('{f, c, r, s, (f == 1 && c == 1 && r == 2 && s == 2)});
        run_job(0, 0, 200, 1'b0, acc_h, stalls);
        checks++;
        if (stalls != 0) begin
            failures++;
            $display("FAIL sweep_stalls got=%0d expected=0", stalls);
        end
    endtask

    task automatic test_backpressure();
        int acc_h;
        int stalls;
        num_ch = 5'd3; num_rows = 4'd2; num_cols = 6'd5;
        for (int i = 0; i < 14; i++)
            tup_q.push_back('{$urandom_range(255), $urandom_range(31), $urandom_range(15),
                              $urandom_range(63), (i == 13)});
        run_job(0, 20, 300, 1'b0, acc_h, stalls);
        checks++;
        if (acc_h != DEPTH) begin
            failures++;
            $display("FAIL bp_accepts got=%0d expected=%0d", acc_h, DEPTH);
        end
    endtask

    task automatic test_toggle_full();
        int acc_h;
        int stalls;
        num_ch = 5'd4; num_rows = 4'd4; num_cols = 6'd4;
        for (int i = 0; i < 24; i++)
            tup_q.push_back('{$urandom_range(255), $urandom_range(31), $urandom_range(15),
                              $urandom_range(63), (i == 23)});
        run_job(2, 12, 400, 1'b0, acc_h, stalls);
    endtask

    task automatic test_truncation();
        int acc_h;
        int stalls;
        num_ch = 5'd31; num_rows = 4'd15; num_cols = 6'd63;
        tup_q.push_back('{255, 30, 14, 62, 1'b1});
        run_job(0, 0, 50, 1'b0, acc_h, stalls);
    endtask

    task automatic test_reset_midstream();
        int acc_h;
        int stalls;
        num_ch = 5'd3; num_rows = 4'd3; num_cols = 6'd7;
        @(negedge clk); start = 1'b1; w_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            idx_valid = 1'b1; idx_last = 1'b0;
            filter_index = F_W'($urandom); channel_index = C_W'($urandom);
            row_index = R_W'($urandom); col_index = S_W'($urandom);
            @(negedge clk);
        end
        idx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (w_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_buffered got w_valid=%b expected=1", w_valid);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (w_valid !== 1'b0 || await !== 1'b1 || busy !== 1'b0 || mem_ren !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got v=%b await=%b busy=%b ren=%b expected 0/1/0/0",
                     w_valid, await, busy, mem_ren);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (w_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_ghost cyc=%0d got w_valid=%b expected=0", i, w_valid);
            end
        end
        num_ch = 5'd2; num_rows = 4'd5; num_cols = 6'd9;
        for (int i = 0; i < 10; i++)
            tup_q.push_back('{$urandom_range(255), $urandom_range(1), $urandom_range(4),
                              $urandom_range(8), (i == 9)});
        run_job(1, 0, 300, 1'b1, acc_h, stalls);
    endtask

    task automatic test_random();
        int acc_h;
        int stalls;
        for (int j = 0; j < 3; j++) begin
            num_ch = C_W'($urandom_range(31, 1));
            num_rows = R_W'($urandom_range(15, 1));
            num_cols = S_W'($urandom_range(63, 1));
            for (int i = 0; i < 40; i++)
                tup_q.push_back('{$urandom_range(255), $urandom_range(31), $urandom_range(15),
                                  $urandom_range(63), (i == 39)});
            run_job(1, 0, 1000, 1'b1, acc_h, stalls);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; idx_valid = 1'b0; idx_last = 1'b0; w_ready = 1'b0;
        num_ch = 5'd1; num_rows = 4'd1; num_cols = 6'd1;
        filter_index = 8'd0; channel_index = 5'd0; row_index = 4'd0; col_index = 6'd0;
        test_reset();
        test_single_tuple();
        test_sweep();
        test_backpressure();
        test_toggle_full();
        test_truncation();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
